// File: rtl/alu_cdb_unit_pkg.sv
// Shared constants, types and small decode helpers for the ALU / CDB execution unit.
// Optional branch resolution is enabled by defining ALU_BRANCH_EN.
package alu_cdb_unit_pkg;

    localparam int unsigned ROB_IDX_W_DEF = 5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_fn_e;

    typedef struct packed {
        logic [31:0] value;
        logic        br_taken;
        logic [31:0] br_target;
    } alu_res_t;

    // SUB only exists for register-register ops; immediates always add.
    function automatic alu_fn_e decode_fn(input logic [2:0] funct3,
                                          input logic       funct7_5,
                                          input logic       sub_ok);
        alu_fn_e fn;
        case (funct3)
            F3_ADD:  fn = (funct7_5 && sub_ok) ? ALU_SUB : ALU_ADD;
            F3_SLL:  fn = ALU_SLL;
            F3_SLT:  fn = ALU_SLT;
            F3_SLTU: fn = ALU_SLTU;
            F3_XOR:  fn = ALU_XOR;
            F3_SR:   fn = funct7_5 ? ALU_SRA : ALU_SRL;
            F3_OR:   fn = ALU_OR;
            F3_AND:  fn = ALU_AND;
            default: fn = ALU_ADD;
        endcase
        return fn;
    endfunction

    function automatic logic br_cond(input logic [2:0]  funct3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        logic c;
        case (funct3)
            F3_BEQ:  c = (a == b);
            F3_BNE:  c = (a != b);
            F3_BLT:  c = ($signed(a) <  $signed(b));
            F3_BGE:  c = ($signed(a) >= $signed(b));
            F3_BLTU: c = (a <  b);
            F3_BGEU: c = (a >= b);
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_cdb_unit_alu_core.sv
// Combinational RV32I integer datapath: rd value plus optional branch/jump resolution.
// Branch outcome and target are produced only when ALU_BRANCH_EN is defined; otherwise both are zero.
module alu_core
    import alu_cdb_unit_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7_5_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] pc_i,
    output alu_res_t    res_o
);

    alu_fn_e     fn_s;
    logic [31:0] op2_s;
    logic [4:0]  shamt_s;
    logic [31:0] alu_s;
    logic [31:0] value_s;
    logic [31:0] pc4_s;
    logic [31:0] pc_imm_s;
    logic        taken_s;
    logic [31:0] target_s;

    assign op2_s    = (opcode_i == OP_I) ? imm_i : rs2_i;
    assign shamt_s  = op2_s[4:0];
    assign pc4_s    = pc_i + 32'd4;
    assign pc_imm_s = pc_i + imm_i;

    // Operation select from funct3/funct7_5.
    always_comb begin
        fn_s = decode_fn(funct3_i, funct7_5_i, (opcode_i == OP_R));
    end

    // Arithmetic/logic result for R and I formats.
    always_comb begin
        alu_s = 32'd0;
        case (fn_s)
            ALU_ADD:  alu_s = rs1_i + op2_s;
            ALU_SUB:  alu_s = rs1_i - op2_s;
            ALU_SLL:  alu_s = rs1_i << shamt_s;
            ALU_SLT:  alu_s = {31'd0, ($signed(rs1_i) < $signed(op2_s))};
            ALU_SLTU: alu_s = {31'd0, (rs1_i < op2_s)};
            ALU_XOR:  alu_s = rs1_i ^ op2_s;
            ALU_SRL:  alu_s = rs1_i >> shamt_s;
            ALU_SRA:  alu_s = $signed(rs1_i) >>> shamt_s;
            ALU_OR:   alu_s = rs1_i | op2_s;
            ALU_AND:  alu_s = rs1_i & op2_s;
            default:  alu_s = 32'd0;
        endcase
    end

    // rd value per opcode; unknown opcodes and branches still broadcast zero.
    always_comb begin
        value_s = 32'd0;
        case (opcode_i)
            OP_R, OP_I:       value_s = alu_s;
            OP_LUI:           value_s = imm_i;
            OP_AUIPC:         value_s = pc_imm_s;
            OP_JAL, OP_JALR:  value_s = pc4_s;
            OP_BR:            value_s = 32'd0;
            default:          value_s = 32'd0;
        endcase
    end

`ifdef ALU_BRANCH_EN
    logic [31:0] jalr_sum_s;
    assign jalr_sum_s = rs1_i + imm_i;

    // Control-flow resolution; straight-line ops report fall-through.
    always_comb begin
        taken_s  = 1'b0;
        target_s = pc4_s;
        case (opcode_i)
            OP_BR: begin
                taken_s  = br_cond(funct3_i, rs1_i, rs2_i);
                target_s = pc_imm_s;
            end
            OP_JAL: begin
                taken_s  = 1'b1;
                target_s = pc_imm_s;
            end
            OP_JALR: begin
                taken_s  = 1'b1;
                target_s = {jalr_sum_s[31:1], 1'b0};
            end
            default: begin
                taken_s  = 1'b0;
                target_s = pc4_s;
            end
        endcase
    end
`else
    assign taken_s  = 1'b0;
    assign target_s = 32'd0;
`endif

    assign res_o.value     = value_s;
    assign res_o.br_taken  = taken_s;
    assign res_o.br_target = target_s;

endmodule

// File: rtl/alu_cdb_unit.sv
// ALU execution unit: accepts one RS op per cycle, buffers results in a small FIFO and
// broadcasts them on the CDB under arbiter grant. Branch resolution gated by ALU_BRANCH_EN.
module alu_cdb_unit
    import alu_cdb_unit_pkg::*;
#(
    parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEF,
    parameter int unsigned OUT_DEPTH = 2
)(
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 rob_clear_up,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [6:0]           issue_opcode,
    input  logic [2:0]           issue_funct3,
    input  logic                 issue_funct7_5,
    input  logic [31:0]          issue_rs1_v,
    input  logic [31:0]          issue_rs2_v,
    input  logic [31:0]          issue_imm,
    input  logic [31:0]          issue_pc,
    input  logic [ROB_IDX_W-1:0] issue_rob_id,
    output logic                 cdb_valid,
    input  logic                 cdb_grant,
    output logic [ROB_IDX_W-1:0] cdb_rob_id,
    output logic [31:0]          cdb_value,
    output logic                 cdb_br_taken,
    output logic [31:0]          cdb_br_target
);

    localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

    alu_res_t             res_s;
    alu_res_t             res_buf_q [OUT_DEPTH];
    logic [ROB_IDX_W-1:0] id_buf_q  [OUT_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_s;
    logic                 empty_s;
    logic                 flush_s;
    logic                 push_s;
    logic                 pop_s;

    alu_core u_alu_core (
        .opcode_i   (issue_opcode),
        .funct3_i   (issue_funct3),
        .funct7_5_i (issue_funct7_5),
        .rs1_i      (issue_rs1_v),
        .rs2_i      (issue_rs2_v),
        .imm_i      (issue_imm),
        .pc_i       (issue_pc),
        .res_o      (res_s)
    );

    assign full_s      = (count_q == CNT_W'(OUT_DEPTH));
    assign empty_s     = (count_q == {CNT_W{1'b0}});
    assign issue_ready = rdy_in & ~full_s;
    assign cdb_valid   = rdy_in & ~empty_s;

    // A flush overrides any same-cycle issue or grant.
    assign flush_s = rdy_in & rob_clear_up;
    assign push_s  = issue_valid & issue_ready & ~rob_clear_up;
    assign pop_s   = cdb_valid & cdb_grant & ~rob_clear_up;

    // FIFO pointer and occupancy next-state; depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO control state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Result storage; entries are cleared on reset so the idle CDB fields read zero.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < int'(OUT_DEPTH); i++) begin
                res_buf_q[i] <= '0;
                id_buf_q[i]  <= {ROB_IDX_W{1'b0}};
            end
        end else if (push_s) begin
            res_buf_q[wr_ptr_q] <= res_s;
            id_buf_q[wr_ptr_q]  <= issue_rob_id;
        end
    end

    assign cdb_rob_id    = id_buf_q[rd_ptr_q];
    assign cdb_value     = res_buf_q[rd_ptr_q].value;
    assign cdb_br_taken  = res_buf_q[rd_ptr_q].br_taken;
    assign cdb_br_target = res_buf_q[rd_ptr_q].br_target;

endmodule
